decode_issue_controller: RTL and testbench
==========================================

# decode_issue_controller

Single-entry decode-stage controller between fetch and execute. Captures one instruction, registers the immediate-format select that drives the immediate extender, and detects load-use hazards, inserting one bubble. Runs a valid/ready handshake on both sides and discards its entry on a branch/jump flush from execute.

## Interface
- `BIT_COUNT`, default 32: datapath width, forwarded to the downstream immediate extender; must be ≥ 32.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `InstrF` in 32: instruction word from fetch.
- `InstrValidF` in 1: fetch offers `InstrF`.
- `InstrReadyD` out 1: controller accepts `InstrF` this cycle (combinational).
- `FlushD` in 1: branch/jump redirect from execute; kills the held entry.
- `ExReadyE` in 1: execute accepts the issued instruction this cycle.
- `InstrD` out 32: registered instruction to the register file and immediate extender.
- `ImmSrcD` out `immSrc`: registered immediate format for the extender.
- `InstrValidD` out 1: `InstrD` is issuable this cycle.
- `IllegalD` out 1: registered flag; held opcode is unrecognised.

## Operation
- States:
  - EMPTY: no entry.
  - VALID: entry held and issuable.
  - STALL: entry held and blocked by a load-use hazard.
- Definitions:
  - Accept = `InstrValidF & InstrReadyD & !FlushD`.
  - Issue = `InstrValidD & ExReadyE`.
  - `InstrValidD` = (state == VALID).
  - `InstrReadyD` = (state == EMPTY) | Issue.
- On accept, `InstrD`, `ImmSrcD` and `IllegalD` load from the decode of `InstrF`.
- Immediate decode by opcode `InstrF[6:0]`:
  - 0010011 with funct3 001/101 → Imm4t0.
  - Other 0010011, 0000011 and 1100111 → Imm11t0.
  - 0100011 → SType.
  - 0110111 and 0010111 → UType.
  - 1101111 → JType.
  - 1100011 → BType.
  - 0110011 → Imm11t0 (unused).
  - Any other opcode → Imm11t0 with `IllegalD`=1.
- Register use:
  - rs1 = `Instr[19:15]` is read by OP-IMM, load, store, branch, JALR and R-type.
  - rs2 = `Instr[24:20]` is read by store, branch and R-type.
  - x0 is never a hazard.
- Load tracker (`LoadPend`, `LoadRd`):
  - Updates only when `ExReadyE`=1.
  - On update, `LoadPend` ← Issue & held opcode is 0000011 & rd≠0, and `LoadRd` ← held rd.
  - When `ExReadyE`=0, the tracker holds its value.
- Hazard = `LoadPend` & an entry register read matches `LoadRd`. The check runs on the incoming instruction at accept and on the held entry each cycle.
- Transitions (flush has highest priority):
  - EMPTY → VALID on accept with no hazard.
  - EMPTY → STALL on accept with a hazard.
  - VALID → EMPTY on Issue without accept.
  - VALID → VALID or STALL on Issue with accept, per the hazard check.
  - VALID with no Issue holds its entry.
  - STALL → VALID once `LoadPend` clears. STALL never issues.
  - Any state → EMPTY on `FlushD`. Flush also clears `LoadPend`. An instruction offered during a flush cycle is dropped, even though `InstrReadyD` may be 1.
- When the entry drains, `InstrD`, `ImmSrcD` and `IllegalD` hold their last values; only `InstrValidD` falls.

## Timing
- Reset values:
  - state EMPTY.
  - `InstrD` = 32'h0000_0013 (NOP).
  - `ImmSrcD` = Imm11t0.
  - `IllegalD` = 0, `InstrValidD` = 0.
  - `LoadPend` = 0, `LoadRd` = 0.
  - `InstrReadyD` = 1.
- Latency:
  - Instruction accepted at edge t is visible on `InstrD` after t.
  - With no hazard, `InstrValidD`=1 in the first cycle after t.
  - Back-to-back throughput is 1 instruction/cycle.
- Load-use: a dependent instruction issues exactly 2 cycles after its producing load issues, provided `ExReadyE` stays 1. Each cycle `ExReadyE` is low extends the stall by one cycle.
- Reset mid-operation clears the entry and tracker immediately (asynchronous). The first accept is possible in the first cycle after reset deasserts.
- Simultaneous Issue and accept in one cycle: the new entry replaces the old one at that edge, with no bubble unless there is a hazard.
- Simultaneous `FlushD` and Issue: the issue handshake completes in execute, but the controller still goes EMPTY and the tracker clears.

## Test plan
- Reset, then stream addi/lw/sw/lui/jal/beq/slli/0x7F opcodes with `ExReadyE`=1 → the matching `ImmSrcD` is seen for each one cycle after accept, and `IllegalD`=1 only for 0x7F.
- `lw x5,0(x1)` then `add x6,x5,x2` → the add shows `InstrValidD`=0 for exactly one cycle and issues 2 cycles after the lw. Repeat with rd=x0 → no bubble.
- Same load-use pair with `ExReadyE` held low for 3 cycles after the lw issues → STALL persists for 4 cycles, then the add issues.
- `ExReadyE`=0 while `InstrValidF`=1 → `InstrReadyD`=0, `InstrD` is stable, and no instruction is lost or duplicated when `ExReadyE` returns to 1.
- `FlushD`=1 with an entry held and a new instruction offered → next cycle is EMPTY, `InstrValidD`=0, the offered instruction is not issued, and `LoadPend`=0.
- Assert `reset`=0 mid-stream in STALL → all outputs return to their reset values immediately. After release, `addi` is accepted and issues the next cycle.

Source files
------------

// File: rtl/decode_issue_controller.sv
// decode_issue_controller: single-entry decode stage with immediate-format decode,
// load-use bubble insertion and valid/ready handshakes toward fetch and execute.
module decode_issue_controller #(
   parameter int BIT_COUNT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] InstrF,
   input  logic        InstrValidF,
   output logic        InstrReadyD,
   input  logic        FlushD,
   input  logic        ExReadyE,
   output logic [31:0] InstrD,
   output logic [2:0]  ImmSrcD,
   output logic        InstrValidD,
   output logic        IllegalD
);
   if (BIT_COUNT < 32) begin : g_width_check
      $error("decode_issue_controller: BIT_COUNT must be at least 32");
   end
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] VALID = 2'd1;
   localparam logic [1:0] STALL = 2'd2;
   localparam logic [2:0] IMM_11T0 = 3'd0;
   localparam logic [2:0] IMM_S    = 3'd1;
   localparam logic [2:0] IMM_B    = 3'd2;
   localparam logic [2:0] IMM_U    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;
   localparam logic [2:0] IMM_4T0  = 3'd5;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   logic [1:0]  state, state_nx;
   logic        load_pend, pend_nx;
   logic [4:0]  load_rd, rd_nx;
   logic        issue, accept, haz_f, haz_d, ill_f;
   logic [2:0]  imm_f;

   function automatic logic [2:0] imm_sel(input logic [6:0] op, input logic [2:0] f3);
      return (op == OP_IMM && f3[1:0] == 2'b01) ? IMM_4T0 :
             (op == OP_STORE)                   ? IMM_S   :
             (op == OP_LUI || op == OP_AUIPC)   ? IMM_U   :
             (op == OP_JAL)                     ? IMM_J   :
             (op == OP_BR)                      ? IMM_B   : IMM_11T0;
   endfunction

   function automatic logic known(input logic [6:0] op);
      return op == OP_IMM || op == OP_LOAD || op == OP_JALR || op == OP_STORE ||
             op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_BR || op == OP_REG;
   endfunction

   // Compares against the tracker value that will hold after this edge, so a load
   // issuing in the same cycle already blocks its consumer.
   function automatic logic hazard(input logic [6:0] op, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic p, input logic [4:0] r);
      logic use1, use2;
      use1 = op == OP_IMM || op == OP_LOAD || op == OP_STORE || op == OP_BR ||
             op == OP_JALR || op == OP_REG;
      use2 = op == OP_STORE || op == OP_BR || op == OP_REG;
      return p && r != 5'd0 && ((use1 && rs1 == r) || (use2 && rs2 == r));
   endfunction

   always_comb begin
      InstrValidD = state == VALID;
      issue       = InstrValidD & ExReadyE;
      InstrReadyD = (state == EMPTY) | issue;
      accept      = InstrValidF & InstrReadyD & ~FlushD;
      pend_nx     = FlushD ? 1'b0 :
                    ExReadyE ? (issue && InstrD[6:0] == OP_LOAD && InstrD[11:7] != 5'd0) : load_pend;
      rd_nx       = ExReadyE ? InstrD[11:7] : load_rd;
      imm_f       = imm_sel(InstrF[6:0], InstrF[14:12]);
      ill_f       = ~known(InstrF[6:0]);
      haz_f       = hazard(InstrF[6:0], InstrF[19:15], InstrF[24:20], pend_nx, rd_nx);
      haz_d       = hazard(InstrD[6:0], InstrD[19:15], InstrD[24:20], pend_nx, rd_nx);
      state_nx    = FlushD ? EMPTY :
                    accept ? (haz_f ? STALL : VALID) :
                    issue  ? EMPTY :
                    (state == STALL && !haz_d) ? VALID : state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         InstrD    <= 32'h0000_0013;
         ImmSrcD   <= IMM_11T0;
         IllegalD  <= 1'b0;
         load_pend <= 1'b0;
         load_rd   <= 5'd0;
      end else begin
         state     <= state_nx;
         load_pend <= pend_nx;
         load_rd   <= rd_nx;
         if (accept) begin
            InstrD   <= InstrF;
            ImmSrcD  <= imm_f;
            IllegalD <= ill_f;
         end
      end
   end
endmodule

// File: tb/tb_decode_issue_controller.sv
// tb_decode_issue_controller: directed and randomized checks of decode_issue_controller
// against a queue-free behavioural model of entry occupancy and load dependence.
module tb_decode_issue_controller;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] InstrF = 32'h13;
   logic        InstrValidF = 1'b0, FlushD = 1'b0, ExReadyE = 1'b1;
   logic        InstrReadyD, InstrValidD, IllegalD;
   logic [31:0] InstrD;
   logic [2:0]  ImmSrcD;
   int          checks = 0, errors = 0;

   decode_issue_controller #(.BIT_COUNT(32)) dut (
      .clk(clk), .reset(reset), .InstrF(InstrF), .InstrValidF(InstrValidF),
      .InstrReadyD(InstrReadyD), .FlushD(FlushD), .ExReadyE(ExReadyE), .InstrD(InstrD),
      .ImmSrcD(ImmSrcD), .InstrValidD(InstrValidD), .IllegalD(IllegalD));

   always #5 clk = ~clk;

   localparam logic [31:0] ADDI  = 32'h0010_0093;
   localparam logic [31:0] LW5   = 32'h0000_A283;
   localparam logic [31:0] LW0   = 32'h0000_A003;
   localparam logic [31:0] ADD65 = 32'h0022_8333;
   localparam logic [31:0] SUBX  = 32'h4030_8233;

   logic [31:0] tbl[8] = '{32'h0010_0093, 32'h0000_A383, 32'h0020_A023, 32'h0000_12B7,
                           32'h0080_00EF, 32'h0020_8463, 32'h0010_9093, 32'h0000_007F};
   logic [2:0]  imm_e[8] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd4, 3'd2, 3'd5, 3'd0};
   logic        ill_e[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [6:0]  ops[10] = '{7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h67, 7'h33, 7'h7F};

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // Model: an occupied entry, plus "a load with destination m_prd is still in flight".
   logic        m_full = 1'b0, m_pend = 1'b0, m_ill = 1'b0;
   logic [4:0]  m_prd = 5'd0;
   logic [31:0] m_instr = 32'h13;
   logic [2:0]  m_imm = 3'd0;
   logic        u_v, u_iss, u_acc, c_v;

   function automatic logic [2:0] imm_of(input logic [31:0] i);
      case (i[6:0])
         7'h13:        return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd5 : 3'd0;
         7'h23:        return 3'd1;
         7'h63:        return 3'd2;
         7'h37, 7'h17: return 3'd3;
         7'h6F:        return 3'd4;
         default:      return 3'd0;
      endcase
   endfunction

   function automatic logic ill_of(input logic [31:0] i);
      case (i[6:0])
         7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h33: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
      logic [6:0] op;
      op = i[6:0];
      if (r == 5'd0) return 1'b0;
      if ((op == 7'h23 || op == 7'h63 || op == 7'h33) && i[24:20] == r) return 1'b1;
      return (op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 ||
              op == 7'h67 || op == 7'h33) && i[19:15] == r;
   endfunction

   function automatic logic exp_valid();
      return m_full && !(m_pend && reads(m_instr, m_prd));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_full = 1'b0; m_pend = 1'b0; m_prd = 5'd0;
         m_instr = 32'h13; m_imm = 3'd0; m_ill = 1'b0;
      end else begin
         u_v   = exp_valid();
         u_iss = u_v && ExReadyE;
         u_acc = InstrValidF && (!m_full || u_iss) && !FlushD;
         if (FlushD) m_pend = 1'b0;
         else if (ExReadyE) begin
            m_pend = u_iss && m_instr[6:0] == 7'h03 && m_instr[11:7] != 5'd0;
            m_prd  = m_instr[11:7];
         end
         if (u_acc) begin
            m_full = 1'b1; m_instr = InstrF; m_imm = imm_of(InstrF); m_ill = ill_of(InstrF);
         end else if (u_iss || FlushD) m_full = 1'b0;
      end
   end

   always @(negedge clk) begin
      c_v = exp_valid();
      chk("valid", InstrValidD, c_v);
      chk("ready", InstrReadyD, !m_full || (c_v && ExReadyE));
      chk("instr", InstrD, m_instr);
      chk("immsrc", ImmSrcD, m_imm);
      chk("illegal", IllegalD, m_ill);
   end

   task automatic cyc(input logic [31:0] i, input logic v, input logic f, input logic e);
      @(posedge clk);
      #2;
      InstrF = i; InstrValidF = v; FlushD = f; ExReadyE = e;
   endtask

   task automatic load_use(input string n, input logic [31:0] ld, input logic [31:0] use_i,
                           input int low, input int exp_bub);
      int bub;
      bub = 0;
      cyc(ld, 1, 0, 1);
      cyc(use_i, 1, 0, 1);
      #2 chk({n, "_ld_valid"}, InstrValidD, 1'b1);
      chk({n, "_ld_instr"}, InstrD, ld);
      for (int c = 0; c < 10; c++) begin
         cyc(32'h13, 0, 0, c >= low);
         #2;
         if (InstrValidD) break;
         bub++;
      end
      chk({n, "_bubbles"}, bub, exp_bub);
      chk({n, "_use_instr"}, InstrD, use_i);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      i = $urandom;
      i[6:0]   = ops[$urandom_range(0, 9)];
      i[11:7]  = 5'($urandom_range(0, 3));
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
      return i;
   endfunction

   initial begin
      @(posedge clk);
      #2;
      chk("rst_instr", InstrD, 32'h0000_0013);
      chk("rst_imm", ImmSrcD, 3'd0);
      chk("rst_ready", InstrReadyD, 1'b1);
      chk("rst_valid", InstrValidD, 1'b0);
      reset = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         cyc(k < 8 ? tbl[k % 8] : 32'h13, k < 8, 0, 1);
         #2;
         if (k > 0) begin
            chk("stream_instr", InstrD, tbl[k - 1]);
            chk("stream_imm", ImmSrcD, imm_e[k - 1]);
            chk("stream_ill", IllegalD, ill_e[k - 1]);
            chk("stream_valid", InstrValidD, 1'b1);
         end
      end
      load_use("lu", LW5, ADD65, 0, 1);
      load_use("lu_x0", LW0, ADD65, 0, 0);
      load_use("lu_slow", LW5, ADD65, 3, 4);
      cyc(ADDI, 1, 0, 1);
      cyc(SUBX, 1, 0, 0);
      #2 chk("bp_ready", InstrReadyD, 1'b0);
      cyc(SUBX, 1, 0, 0);
      #2 chk("bp_hold", InstrD, ADDI);
      cyc(SUBX, 1, 0, 1);
      cyc(32'h13, 0, 0, 1);
      #2 chk("bp_next", InstrD, SUBX);
      chk("bp_next_valid", InstrValidD, 1'b1);
      cyc(ADDI, 1, 0, 0);
      cyc(SUBX, 1, 1, 1);
      cyc(32'h13, 0, 0, 1);
      #2 chk("fl_valid", InstrValidD, 1'b0);
      chk("fl_dropped", InstrD, ADDI);
      cyc(LW5, 1, 0, 1);
      cyc(ADD65, 1, 1, 1);
      cyc(ADD65, 1, 0, 1);
      cyc(32'h13, 0, 0, 1);
      #2 chk("fl_pend_clear", InstrValidD, 1'b1);
      cyc(LW5, 1, 0, 1);
      cyc(ADD65, 1, 0, 1);
      cyc(32'h13, 0, 0, 1);
      #2 chk("rs_stalled", InstrValidD, 1'b0);
      reset = 1'b0;
      #1 chk("rs_instr", InstrD, 32'h0000_0013);
      chk("rs_valid", InstrValidD, 1'b0);
      chk("rs_ready", InstrReadyD, 1'b1);
      @(posedge clk);
      #2 reset = 1'b1;
      cyc(ADDI, 1, 0, 1);
      cyc(32'h13, 0, 0, 1);
      #2 chk("rs_after", InstrD, ADDI);
      chk("rs_after_valid", InstrValidD, 1'b1);
      repeat (3000)
         cyc(rand_instr(), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
